// File: rtl/cardinal_router_if.sv
// cardinal_router_if: five flit ports of the mesh router (up, down, left, right, NIC).
// Per port: si/di/ri carry flits into the router, so/do/ro carry flits out of it.
// master: the tile side that feeds and drains the router; slave: the router itself.
interface cardinal_router_if;
  localparam int unsigned FLIT_W = 64;

  logic              up_si, down_si, left_si, right_si, NIC_si;
  logic [FLIT_W-1:0] up_di, down_di, left_di, right_di, NIC_di;
  logic              up_ri, down_ri, left_ri, right_ri, NIC_ri;
  logic              up_so, down_so, left_so, right_so, NIC_so;
  logic [FLIT_W-1:0] up_do, down_do, left_do, right_do, NIC_do;
  logic              up_ro, down_ro, left_ro, right_ro, NIC_ro;

  modport master (
    output up_si, down_si, left_si, right_si, NIC_si,
    output up_di, down_di, left_di, right_di, NIC_di,
    input  up_ri, down_ri, left_ri, right_ri, NIC_ri,
    input  up_so, down_so, left_so, right_so, NIC_so,
    input  up_do, down_do, left_do, right_do, NIC_do,
    output up_ro, down_ro, left_ro, right_ro, NIC_ro
  );

  modport slave (
    input  up_si, down_si, left_si, right_si, NIC_si,
    input  up_di, down_di, left_di, right_di, NIC_di,
    output up_ri, down_ri, left_ri, right_ri, NIC_ri,
    output up_so, down_so, left_so, right_so, NIC_so,
    output up_do, down_do, left_do, right_do, NIC_do,
    input  up_ro, down_ro, left_ro, right_ro, NIC_ro
  );
endinterface

// File: rtl/cardinal_router.sv
// cardinal_router: five-port mesh tile router with two virtual channels.
// A global polarity P toggles every cycle; VC P faces the external links while
// VC !P is switched internally (source-routed, X first, then Y, then NIC).
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset, clears all state
//   bus             five flit ports (slave modport of cardinal_router_if)
//   polarity_to_NIC current polarity P, keeps the attached NIC in phase
module cardinal_router (
  input  logic             clk,
  input  logic             reset,
  cardinal_router_if.slave bus,
  output logic             polarity_to_NIC
);
  localparam int unsigned FLIT_W = 64;
  localparam int unsigned NPORT  = 5;
  localparam int unsigned PW     = 3;

  // Port indices; ascending order is also the round-robin scan order.
  localparam logic [PW-1:0] UP    = 3'd0;
  localparam logic [PW-1:0] RIGHT = 3'd1;
  localparam logic [PW-1:0] DOWN  = 3'd2;
  localparam logic [PW-1:0] LEFT  = 3'd3;
  localparam logic [PW-1:0] NIC   = 3'd4;

  typedef logic [FLIT_W-1:0] flit_t;

  logic                       p;
  logic                       q;
  logic [NPORT-1:0]           si, ri, so, ro;
  flit_t                      di   [NPORT];
  flit_t                      dout [NPORT];

  logic [NPORT-1:0][1:0]      in_full;
  logic [NPORT-1:0][1:0]      out_full;
  flit_t                      in_data  [NPORT][2];
  flit_t                      out_data [NPORT][2];
  logic [PW-1:0]              rr_ptr   [NPORT];

  logic [PW-1:0]              tgt      [NPORT];
  flit_t                      fwd      [NPORT];
  logic [NPORT-1:0][NPORT-1:0] req;
  logic [NPORT-1:0]           gnt_vld;
  logic [PW-1:0]              gnt_src  [NPORT];
  logic [NPORT-1:0]           in_won;

  // Port flattening between the interface and indexed arrays.
  assign si = {bus.NIC_si, bus.left_si, bus.down_si, bus.right_si, bus.up_si};
  assign ro = {bus.NIC_ro, bus.left_ro, bus.down_ro, bus.right_ro, bus.up_ro};
  assign di[UP]    = bus.up_di;
  assign di[RIGHT] = bus.right_di;
  assign di[DOWN]  = bus.down_di;
  assign di[LEFT]  = bus.left_di;
  assign di[NIC]   = bus.NIC_di;

  assign bus.up_ri    = ri[UP];
  assign bus.right_ri = ri[RIGHT];
  assign bus.down_ri  = ri[DOWN];
  assign bus.left_ri  = ri[LEFT];
  assign bus.NIC_ri   = ri[NIC];
  assign bus.up_so    = so[UP];
  assign bus.right_so = so[RIGHT];
  assign bus.down_so  = so[DOWN];
  assign bus.left_so  = so[LEFT];
  assign bus.NIC_so   = so[NIC];
  assign bus.up_do    = dout[UP];
  assign bus.right_do = dout[RIGHT];
  assign bus.down_do  = dout[DOWN];
  assign bus.left_do  = dout[LEFT];
  assign bus.NIC_do   = dout[NIC];

  assign q               = ~p;
  assign polarity_to_NIC = p;

  // External side: VC P accepts into inbufs and drains outbufs.
  always_comb begin
    for (int x = 0; x < NPORT; x++) begin
      ri[x]   = ~in_full[x][p];
      so[x]   = out_full[x][p] & ro[x];
      dout[x] = out_data[x][p];
    end
  end

  // Route each internal-VC inbuf head and decrement the consumed hop count.
  always_comb begin
    for (int x = 0; x < NPORT; x++) begin
      fwd[x] = in_data[x][q];
      tgt[x] = NIC;
      if (in_data[x][q][55:52] != 4'd0) begin
        tgt[x]         = in_data[x][q][62] ? LEFT : RIGHT;
        fwd[x][55:52]  = in_data[x][q][55:52] - 4'd1;
      end else if (in_data[x][q][51:48] != 4'd0) begin
        tgt[x]         = in_data[x][q][61] ? DOWN : UP;
        fwd[x][51:48]  = in_data[x][q][51:48] - 4'd1;
      end
    end
  end

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int unsigned k);
    logic [PW:0] s;
    s = (PW+1)'(base) + (PW+1)'(k);
    if (s >= (PW+1)'(NPORT)) s = s - (PW+1)'(NPORT);
    return PW'(s);
  endfunction

  // Per-output round-robin arbitration, only when the internal-VC outbuf is free.
  always_comb begin
    req     = '0;
    gnt_vld = '0;
    in_won  = '0;
    for (int y = 0; y < NPORT; y++) begin
      gnt_src[y] = UP;
      for (int x = 0; x < NPORT; x++) begin
        req[y][x] = in_full[x][q] && (tgt[x] == PW'(y)) && !out_full[y][q];
      end
      for (int k = 0; k < NPORT; k++) begin
        if (!gnt_vld[y] && req[y][rr_idx(rr_ptr[y], k)]) begin
          gnt_vld[y] = 1'b1;
          gnt_src[y] = rr_idx(rr_ptr[y], k);
        end
      end
    end
    for (int y = 0; y < NPORT; y++) begin
      if (gnt_vld[y]) in_won[gnt_src[y]] = 1'b1;
    end
  end

  // Buffer, polarity and pointer state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p        <= 1'b0;
      in_full  <= '0;
      out_full <= '0;
      for (int x = 0; x < NPORT; x++) begin
        rr_ptr[x] <= UP;
        for (int v = 0; v < 2; v++) begin
          in_data[x][v]  <= '0;
          out_data[x][v] <= '0;
        end
      end
    end else begin
      p <= ~p;
      for (int x = 0; x < NPORT; x++) begin
        if (si[x] && ri[x]) begin
          in_data[x][p] <= di[x];
          in_full[x][p] <= 1'b1;
        end
        if (in_won[x]) in_full[x][q] <= 1'b0;
        if (so[x]) out_full[x][p] <= 1'b0;
        if (gnt_vld[x]) begin
          out_data[x][q] <= fwd[gnt_src[x]];
          out_full[x][q] <= 1'b1;
          rr_ptr[x]      <= (gnt_src[x] == NIC) ? UP : gnt_src[x] + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cardinal_router.sv
// tb_cardinal_router: directed plan cases plus randomized traffic checked
// against a transaction-level scoreboard (per-source, per-VC ordering).
module tb_cardinal_router;
  localparam int UP = 0, RIGHT = 1, DOWN = 2, LEFT = 3, NIC = 4;

  logic        clk;
  logic        reset;
  logic        polarity_to_NIC;
  logic [4:0]  si, ro, ri, so;
  logic [63:0] di   [5];
  logic [63:0] dout [5];
  logic        tb_p;

  int n_checks = 0;
  int n_fail   = 0;
  int out_cnt [5];

  typedef struct {
    int          src;
    int          dst;
    logic [63:0] flit;
  } exp_t;
  exp_t sb[$];

  cardinal_router_if bus ();

  cardinal_router dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .polarity_to_NIC (polarity_to_NIC)
  );

  assign bus.up_si = si[UP];    assign bus.right_si = si[RIGHT]; assign bus.down_si = si[DOWN];
  assign bus.left_si = si[LEFT]; assign bus.NIC_si = si[NIC];
  assign bus.up_di = di[UP];    assign bus.right_di = di[RIGHT]; assign bus.down_di = di[DOWN];
  assign bus.left_di = di[LEFT]; assign bus.NIC_di = di[NIC];
  assign bus.up_ro = ro[UP];    assign bus.right_ro = ro[RIGHT]; assign bus.down_ro = ro[DOWN];
  assign bus.left_ro = ro[LEFT]; assign bus.NIC_ro = ro[NIC];
  assign ri = {bus.NIC_ri, bus.left_ri, bus.down_ri, bus.right_ri, bus.up_ri};
  assign so = {bus.NIC_so, bus.left_so, bus.down_so, bus.right_so, bus.up_so};
  assign dout[UP] = bus.up_do;  assign dout[RIGHT] = bus.right_do; assign dout[DOWN] = bus.down_do;
  assign dout[LEFT] = bus.left_do; assign dout[NIC] = bus.NIC_do;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference polarity: 0 out of reset, toggles every rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_p <= 1'b0;
    else        tb_p <= ~tb_p;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic vc, input logic xd, input logic yd,
                                     input logic [3:0] hx, input logic [3:0] hy,
                                     input logic [47:0] pl);
    return {vc, xd, yd, 5'b0, hx, hy, pl};
  endfunction

  // One-hop routing rule: X first, then Y, then deliver to NIC.
  function automatic void route(input logic [63:0] f, output int dst, output logic [63:0] g);
    g = f;
    if (f[55:52] != 4'd0) begin
      dst = f[62] ? LEFT : RIGHT;
      g[55:52] = f[55:52] - 4'd1;
    end else if (f[51:48] != 4'd0) begin
      dst = f[61] ? DOWN : UP;
      g[51:48] = f[51:48] - 4'd1;
    end else begin
      dst = NIC;
    end
  endfunction

  // Scoreboard: accepts at negedge (si && ri), matches every so against pending flits.
  always @(negedge clk) begin
    int          idx;
    int          d;
    logic        older;
    logic [63:0] g;
    if (reset) begin
      check("polarity", 64'(polarity_to_NIC), 64'(tb_p));
      check("so_without_ro", 64'(so & ~ro), 64'd0);
      for (int y = 0; y < 5; y++) begin
        if (so[y]) begin
          idx = -1;
          for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].dst == y && sb[i].flit == dout[y]) idx = i;
          check("sb_match", 64'(idx >= 0), 64'd1);
          if (idx >= 0) begin
            older = 1'b0;
            for (int i = 0; i < idx; i++)
              if (sb[i].src == sb[idx].src && sb[i].dst == y && sb[i].flit[63] == dout[y][63])
                older = 1'b1;
            check("sb_order", 64'(older), 64'd0);
            check("sb_vc_phase", 64'(dout[y][63]), 64'(tb_p));
            sb.delete(idx);
          end
          out_cnt[y]++;
        end
      end
      for (int x = 0; x < 5; x++) begin
        if (si[x] && ri[x]) begin
          route(di[x], d, g);
          sb.push_back('{src: x, dst: d, flit: g});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b0;
    si    = '0;
    ro    = '1;
    sb.delete();
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Single flit from src; expects it on dst exactly two edges after acceptance.
  task automatic directed(input string tag, input int src, input logic [63:0] f0,
                          input int dst, input logic [63:0] e0, input int pol);
    logic [63:0] f, e;
    tick();
    if (pol >= 0) while (tb_p !== pol[0]) tick();
    f = f0; f[63] = tb_p;
    e = e0; e[63] = tb_p;
    si[src] = 1'b1; di[src] = f;
    tick();
    si[src] = 1'b0;
    @(negedge clk);
    check({tag, "_lat1_so"}, 64'(so[dst]), 64'd0);
    tick();
    @(negedge clk);
    check({tag, "_so"}, 64'(so[dst]), 64'd1);
    check({tag, "_do"}, dout[dst], e);
  endtask

  // up and left both target right on the same VC; 'first' must win first.
  task automatic contend(input string tag, input int first, input int second);
    logic [63:0] f [5];
    tick();
    f[UP]   = mk(tb_p, 1'b0, 1'b0, 4'd1, 4'd0, 48'h0000_0000_00A1);
    f[LEFT] = mk(tb_p, 1'b0, 1'b0, 4'd1, 4'd0, 48'h0000_0000_00A2);
    si[UP] = 1'b1;   di[UP]   = f[UP];
    si[LEFT] = 1'b1; di[LEFT] = f[LEFT];
    tick();
    si[UP] = 1'b0; si[LEFT] = 1'b0;
    @(negedge clk);
    check({tag, "_c0_so"}, 64'(so[RIGHT]), 64'd0);
    tick(); @(negedge clk);
    check({tag, "_c1_so"}, 64'(so[RIGHT]), 64'd1);
    check({tag, "_c1_do"}, dout[RIGHT], mk(f[first][63], 1'b0, 1'b0, 4'd0, 4'd0, f[first][47:0]));
    tick(); @(negedge clk);
    check({tag, "_c2_so"}, 64'(so[RIGHT]), 64'd0);
    tick(); @(negedge clk);
    check({tag, "_c3_so"}, 64'(so[RIGHT]), 64'd1);
    check({tag, "_c3_do"}, dout[RIGHT], mk(f[second][63], 1'b0, 1'b0, 4'd0, 4'd0, f[second][47:0]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    int seq;
    for (int x = 0; x < 5; x++) begin di[x] = '0; out_cnt[x] = 0; end
    si = '0; ro = '1; reset = 1'b0;

    // Reset held for 4 cycles.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_ri", 64'(ri), 64'h1f);
    check("rst_so", 64'(so), 64'd0);
    check("rst_pol", 64'(polarity_to_NIC), 64'd0);
    for (int y = 0; y < 5; y++) check("rst_do", dout[y], 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("pol_seq", 64'(polarity_to_NIC), 64'(i % 2));
    end

    directed("down_up", DOWN, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 48'h0123_4567_89AB),
             UP, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 48'h0123_4567_89AB), 1);
    directed("left_right", LEFT, mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd1, 48'h0000_1111_2222),
             RIGHT, mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd1, 48'h0000_1111_2222), -1);
    directed("right_left", RIGHT, mk(1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 48'h0000_3333_4444),
             LEFT, mk(1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 48'h0000_3333_4444), -1);
    directed("nic_right", NIC, mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 48'h0000_5555_6666),
             RIGHT, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 48'h0000_5555_6666), -1);
    directed("down_nic", DOWN, mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 48'hDEAD_BEEF_CAFE),
             NIC, mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 48'hDEAD_BEEF_CAFE), -1);

    // Contention: pointer at up after reset, then at NIC, then at right.
    do_reset(2);
    contend("cont1", UP, LEFT);
    contend("cont2", UP, LEFT);
    directed("up_alone", UP, mk(1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 48'h0000_0000_00B0),
             RIGHT, mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'h0000_0000_00B0), -1);
    contend("cont3", LEFT, UP);

    // Backpressure on right: two flits per VC fit (inbuf + outbuf), then ri drops.
    do_reset(2);
    ro[RIGHT] = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      si[LEFT] = 1'b1;
      di[LEFT] = mk(tb_p, 1'b0, 1'b0, 4'd1, 4'd0, 48'(32'h100 + c));
      @(negedge clk);
      if (ri[LEFT]) acc++;
      check("bp_so_low", 64'(so[RIGHT]), 64'd0);
      tick();
    end
    si[LEFT] = 1'b0;
    check("bp_accepted", 64'(acc), 64'd4);
    @(negedge clk); check("bp_ri_low0", 64'(ri[LEFT]), 64'd0);
    tick(); @(negedge clk); check("bp_ri_low1", 64'(ri[LEFT]), 64'd0);
    base = out_cnt[RIGHT];
    tick();
    ro[RIGHT] = 1'b1;
    for (int c = 0; c < 20 && out_cnt[RIGHT] - base < 4; c++) tick();
    check("bp_drained", 64'(out_cnt[RIGHT] - base), 64'd4);
    check("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Randomized traffic with random backpressure and a mid-run reset.
    do_reset(2);
    seq = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset(1);
        @(negedge clk);
        check("midrst_ri", 64'(ri), 64'h1f);
        check("midrst_so", 64'(so), 64'd0);
        tick();
      end
      for (int x = 0; x < 5; x++) begin
        si[x] = ($urandom_range(0, 99) < 45);
        di[x] = {tb_p, 2'($urandom), 5'($urandom), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 48'(seq)};
        seq++;
        ro[x] = ($urandom_range(0, 99) < 70);
      end
      tick();
    end
    si = '0; ro = '1;
    for (int c = 0; c < 100 && sb.size() != 0; c++) tick();
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
